// File: rtl/adxl345_pkg.sv
// ADXL345 sequencer shared definitions.
// Register map, step decode and FSM encoding.
package adxl345_pkg;

  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;

  localparam int RW_BIT     = 15;
  localparam int STEP_COUNT = 10;

  localparam logic [3:0] FIRST_AXIS_STEP = 4'd4;
  localparam logic [3:0] LAST_STEP       = 4'(STEP_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_NEXT,
    S_INTERVAL,
    S_ERROR
  } state_t;

  // Register address targeted by each sequence step.
  function automatic logic [5:0] step_addr(input logic [3:0] s);
    logic [5:0] a;
    case (s)
      4'd0:    a = ADDR_DEVID;
      4'd1:    a = ADDR_DATA_FORMAT;
      4'd2:    a = ADDR_BW_RATE;
      4'd3:    a = ADDR_POWER_CTL;
      default: a = ADDR_DATAX0 + 6'(s - FIRST_AXIS_STEP);
    endcase
    return a;
  endfunction

  // Steps 1..3 are the config writes; all others read.
  function automatic logic step_is_read(input logic [3:0] s);
    return !(s inside {4'd1, 4'd2, 4'd3});
  endfunction

endpackage

// File: rtl/adxl345_sequencer_timer.sv
// Sample interval timer for the ADXL345 sequencer.
// Restart marks count 0; expiry holds until next restart.
module sample_interval_timer #(
  parameter int SAMPLE_DIV = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic expired
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] count;

  // Restart cycle itself is count 0, so the next cycle is count 1.
  // Saturating at LAST latches the expiry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (restart) begin
      count <= CW'(1);
    end else if (count != LAST) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/adxl345_sequencer.sv
// ADXL345 init and sample-burst sequencer.
// Drives a 16-bit SPI controller one word at a time.
module adxl345_sequencer
  import adxl345_pkg::*;
#(
  parameter int         SAMPLE_DIV      = 500000,
  parameter logic [7:0] DATA_FORMAT_VAL = 8'h0B,
  parameter logic [7:0] BW_RATE_VAL     = 8'h0A,
  parameter logic [7:0] POWER_CTL_VAL   = 8'h08,
  parameter logic [7:0] DEVID_EXP       = 8'hE5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        ctrl_busy,
  input  logic [15:0] ctrl_data_out,
  output logic        ctrl_start,
  output logic [15:0] ctrl_data_in,
  output logic [15:0] x_data,
  output logic [15:0] y_data,
  output logic [15:0] z_data,
  output logic        data_valid,
  output logic        init_done,
  output logic        dev_err
);

  state_t     state;
  logic [3:0] step;
  logic [7:0] devid_q;
  logic [7:0] axis_q [0:4];
  logic       tmr_restart;
  logic       tmr_expired;
  logic [7:0] rd_byte;
  logic       hi_unused;

  assign rd_byte     = ctrl_data_out[7:0];
  assign hi_unused   = ^ctrl_data_out[15:8];
  assign tmr_restart = (state == S_ISSUE) && (step == FIRST_AXIS_STEP);

  sample_interval_timer #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (tmr_restart),
    .expired (tmr_expired)
  );

  // Full controller word for a step: {rw, 0, addr, data}.
  function automatic logic [15:0] step_word(input logic [3:0] s);
    logic [15:0] w;
    logic [7:0]  v;
    case (s)
      4'd1:    v = DATA_FORMAT_VAL;
      4'd2:    v = BW_RATE_VAL;
      4'd3:    v = POWER_CTL_VAL;
      default: v = 8'h00;
    endcase
    w = {2'b00, step_addr(s), v};
    w[RW_BIT] = step_is_read(s);
    return w;
  endfunction

  // Sequencer FSM; every output is registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      step         <= '0;
      ctrl_start   <= 1'b0;
      ctrl_data_in <= '0;
      x_data       <= '0;
      y_data       <= '0;
      z_data       <= '0;
      data_valid   <= 1'b0;
      init_done    <= 1'b0;
      dev_err      <= 1'b0;
      devid_q      <= '0;
      for (int i = 0; i < 5; i++) axis_q[i] <= '0;
    end else begin
      ctrl_start <= 1'b0;
      data_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable && !ctrl_busy) begin
            step         <= init_done ? FIRST_AXIS_STEP : 4'd0;
            ctrl_data_in <= step_word(init_done ? FIRST_AXIS_STEP : 4'd0);
            ctrl_start   <= 1'b1;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (ctrl_busy) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!ctrl_busy) begin
            if (step == 4'd0) begin
              devid_q <= rd_byte;
            end else if (step >= FIRST_AXIS_STEP && step != LAST_STEP) begin
              axis_q[3'(step - FIRST_AXIS_STEP)] <= rd_byte;
            end
            // Last byte goes straight out with the shadows: no torn sample.
            if (step == LAST_STEP) begin
              x_data     <= {axis_q[1], axis_q[0]};
              y_data     <= {axis_q[3], axis_q[2]};
              z_data     <= {rd_byte, axis_q[4]};
              data_valid <= 1'b1;
            end
            state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (step == 4'd0 && devid_q != DEVID_EXP) begin
            dev_err <= 1'b1;
            state   <= S_ERROR;
          end else begin
            if (step == 4'd3) init_done <= 1'b1;
            if (step == LAST_STEP) begin
              state <= enable ? S_INTERVAL : S_IDLE;
            end else if (!enable) begin
              state <= S_IDLE;
            end else begin
              step         <= step + 4'd1;
              ctrl_data_in <= step_word(step + 4'd1);
              ctrl_start   <= 1'b1;
              state        <= S_ISSUE;
            end
          end
        end
        S_INTERVAL: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (tmr_expired) begin
            step         <= FIRST_AXIS_STEP;
            ctrl_data_in <= step_word(FIRST_AXIS_STEP);
            ctrl_start   <= 1'b1;
            state        <= S_ISSUE;
          end
        end
        S_ERROR: begin
          state <= S_ERROR;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adxl345_sequencer.sv
// Scoreboard bench for adxl345_sequencer.
// Controller model plus queued expected words and samples.
module tb_adxl345_sequencer;

  localparam int DIV = 200;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        ctrl_busy;
  logic [15:0] ctrl_data_out;
  logic        ctrl_start;
  logic [15:0] ctrl_data_in;
  logic [15:0] x_data, y_data, z_data;
  logic        data_valid;
  logic        init_done;
  logic        dev_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int starts   = 0;

  logic [15:0] exp_cmd [$];
  logic [47:0] exp_smp [$];

  logic [7:0]  devid_resp;
  logic [7:0]  axis_base;
  int          busy_len;
  logic [15:0] cur;
  int          cnt;

  adxl345_sequencer #(
    .SAMPLE_DIV (DIV)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .ctrl_busy     (ctrl_busy),
    .ctrl_data_out (ctrl_data_out),
    .ctrl_start    (ctrl_start),
    .ctrl_data_in  (ctrl_data_in),
    .x_data        (x_data),
    .y_data        (y_data),
    .z_data        (z_data),
    .data_valid    (data_valid),
    .init_done     (init_done),
    .dev_err       (dev_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [7:0] resp(input logic [15:0] w);
    logic [5:0] a;
    a = w[13:8];
    if (a == 6'h00) return devid_resp;
    if (a >= 6'h32 && a <= 6'h37) return axis_base + 8'(a - 6'h32);
    return 8'h00;
  endfunction

  // SPI controller model: busy for busy_len cycles per request.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_busy     <= 1'b0;
      ctrl_data_out <= 16'h0000;
      cnt           <= 0;
      cur           <= 16'h0000;
    end else if (ctrl_start && !ctrl_busy) begin
      cur       <= ctrl_data_in;
      cnt       <= busy_len;
      ctrl_busy <= 1'b1;
    end else if (ctrl_busy) begin
      if (cnt <= 1) begin
        ctrl_busy     <= 1'b0;
        ctrl_data_out <= {8'hFF, resp(cur)};
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output.
  logic        dv_q   = 1'b0;
  logic        busy_q = 1'b0;
  logic [47:0] xyz_q  = '0;
  logic [15:0] e_cmd;
  logic [47:0] e_smp;

  always @(negedge clk) begin
    if (reset_n) begin
      if (ctrl_start) begin
        starts++;
        checks++;
        if (ctrl_busy) begin
          failures++;
          $display("FAIL start_while_busy word=%h", ctrl_data_in);
        end else if (exp_cmd.size() == 0) begin
          failures++;
          $display("FAIL unexpected_start actual=%h required=none",
                   ctrl_data_in);
        end else begin
          e_cmd = exp_cmd.pop_front();
          if (ctrl_data_in !== e_cmd) begin
            failures++;
            $display("FAIL cmd_word actual=%h required=%h",
                     ctrl_data_in, e_cmd);
          end
        end
      end
      if (data_valid) begin
        checks++;
        if (dv_q) begin
          failures++;
          $display("FAIL data_valid_width actual=2+ required=1");
        end else if (exp_smp.size() == 0) begin
          failures++;
          $display("FAIL unexpected_sample actual=%h required=none",
                   {x_data, y_data, z_data});
        end else begin
          e_smp = exp_smp.pop_front();
          if ({x_data, y_data, z_data} !== e_smp) begin
            failures++;
            $display("FAIL sample actual=%h required=%h",
                     {x_data, y_data, z_data}, e_smp);
          end
        end
      end
      if ({x_data, y_data, z_data} !== xyz_q) begin
        checks++;
        if (!data_valid) begin
          failures++;
          $display("FAIL xyz_change_without_valid actual=%h required=%h",
                   {x_data, y_data, z_data}, xyz_q);
        end
      end
      if (busy_q && !ctrl_busy) begin
        checks++;
        if (ctrl_data_in !== cur) begin
          failures++;
          $display("FAIL data_in_stable actual=%h required=%h",
                   ctrl_data_in, cur);
        end
      end
    end
    dv_q   = data_valid;
    busy_q = ctrl_busy;
    xyz_q  = {x_data, y_data, z_data};
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_init();
    exp_cmd.push_back(16'h8000);
    exp_cmd.push_back(16'h310B);
    exp_cmd.push_back(16'h2C0A);
    exp_cmd.push_back(16'h2D08);
  endtask

  task automatic push_burst(input logic [7:0] b);
    for (int i = 0; i < 6; i++) exp_cmd.push_back({8'hB2 + 8'(i), 8'h00});
    exp_smp.push_back({b + 8'd1, b, b + 8'd3, b + 8'd2, b + 8'd5, b + 8'd4});
  endtask

  task automatic wait_dv(input int limit, output int at);
    at = -1;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (data_valid) begin
        at = cyc;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL timeout_data_valid actual=none required=pulse");
  endtask

  task automatic wait_start(input logic [15:0] w, input int limit);
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (ctrl_start && ctrl_data_in == w) return;
    end
    checks++;
    failures++;
    $display("FAIL timeout_start actual=none required=%h", w);
  endtask

  task automatic wait_busy(input int limit);
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (ctrl_busy) return;
    end
    checks++;
    failures++;
    $display("FAIL timeout_busy actual=0 required=1");
  endtask

  int t1, t2, s0;

  initial begin
    reset_n    = 1'b0;
    enable     = 1'b0;
    busy_len   = 2;
    devid_resp = 8'hE5;
    axis_base  = 8'h01;
    repeat (3) @(negedge clk);

    chk("rst_ctrl_start", 64'(ctrl_start), 64'd0);
    chk("rst_data_in", 64'(ctrl_data_in), 64'd0);
    chk("rst_xyz", 64'({x_data, y_data, z_data}), 64'd0);
    chk("rst_valid", 64'(data_valid), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_dev_err", 64'(dev_err), 64'd0);

    // Init then two bursts at the SAMPLE_DIV rate.
    reset_n = 1'b1;
    push_init();
    push_burst(8'h01);
    push_burst(8'h01);
    enable = 1'b1;
    wait_dv(2000, t1);
    chk("init_done_after_cfg", 64'(init_done), 64'd1);
    wait_dv(400, t2);
    enable = 1'b0;
    chk("sample_period", 64'(t2 - t1), 64'd200);
    chk("x_first", 64'(x_data), 64'h0201);
    chk("dev_err_ok", 64'(dev_err), 64'd0);
    repeat (20) @(negedge clk);
    chk("queue_empty_a", 64'(exp_cmd.size()), 64'd0);

    // Drop enable during the step-6 transaction.
    busy_len  = 10;
    axis_base = 8'h11;
    exp_cmd.push_back(16'hB200);
    exp_cmd.push_back(16'hB300);
    exp_cmd.push_back(16'hB400);
    enable = 1'b1;
    wait_start(16'hB400, 500);
    enable = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_x_kept", 64'(x_data), 64'h0201);
    chk("abort_z_kept", 64'(z_data), 64'h0605);
    chk("abort_busy_done", 64'(ctrl_busy), 64'd0);
    chk("queue_empty_b", 64'(exp_cmd.size()), 64'd0);
    push_burst(8'h11);
    enable = 1'b1;
    wait_dv(1000, t1);
    enable = 1'b0;
    chk("resume_y", 64'(y_data), 64'h1413);
    repeat (30) @(negedge clk);

    // Slow controller: bursts run back to back.
    busy_len  = 50;
    axis_base = 8'h21;
    push_burst(8'h21);
    push_burst(8'h21);
    enable = 1'b1;
    wait_dv(2000, t1);
    wait_dv(2000, t2);
    enable = 1'b0;
    chk("slow_period", 64'(t2 - t1), 64'd319);
    repeat (80) @(negedge clk);
    chk("queue_empty_c", 64'(exp_cmd.size()), 64'd0);

    // Reset while waiting on the controller.
    busy_len  = 4;
    axis_base = 8'h41;
    exp_cmd.push_back(16'hB200);
    enable = 1'b1;
    wait_busy(100);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_xyz", 64'({x_data, y_data, z_data}), 64'd0);
    chk("mid_rst_data_in", 64'(ctrl_data_in), 64'd0);
    chk("mid_rst_init_done", 64'(init_done), 64'd0);
    chk("mid_rst_start", 64'(ctrl_start), 64'd0);
    repeat (3) @(negedge clk);
    exp_cmd.delete();
    exp_smp.delete();
    push_init();
    push_burst(8'h41);
    reset_n = 1'b1;
    wait_dv(2000, t1);
    enable = 1'b0;
    chk("restart_init_done", 64'(init_done), 64'd1);
    repeat (30) @(negedge clk);
    chk("queue_empty_d", 64'(exp_cmd.size()), 64'd0);

    // Wrong DEVID: sticky error, no further requests.
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    exp_cmd.delete();
    exp_smp.delete();
    devid_resp = 8'h00;
    busy_len   = 2;
    exp_cmd.push_back(16'h8000);
    s0 = starts;
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (1010) @(negedge clk);
    chk("dev_err_set", 64'(dev_err), 64'd1);
    chk("err_start_count", 64'(starts - s0), 64'd1);
    chk("err_init_done", 64'(init_done), 64'd0);
    chk("queue_empty_e", 64'(exp_cmd.size()), 64'd0);
    enable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
